// File: rtl/wbc_toggle_bank.sv
// ----------------------------------------------------------------------------
// wbc_toggle_bank
//
// Purpose:
//   Multi-channel push-button front end. Each active-low button is
//   synchronised, debounced against the system millisecond strobe, and
//   turned into a per-channel output in level, toggle or pulse mode, plus a
//   one-clock press strobe. An optional long-press strobe is available.
//
// Optional feature:
//   WBC_TOGGLE_LONG_EN - when defined, every channel gets a hold counter that
//   produces exactly one long[i] strobe per press once the button has been
//   held LONG_MS milliseconds after acceptance. When undefined, no hold
//   counters exist and long is tied to 0.
//
// Parameters:
//   CHANNELS     number of button channels (1..16)
//   DEBOUNCE_MS  contiguous ms a new level must hold before it is accepted
//   MODE         2 bits per channel: 00 level, 01 toggle, 10 pulse, 11 level
//   INIT         reset value of out[i] for toggle-mode channels
//   LONG_MS      long-press threshold in ms
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous reset, active high
//   ena_ms  in   one-clock millisecond strobe
//   but_n   in   raw buttons, active low, asynchronous to clk
//   out     out  per-channel mode output (registered)
//   press   out  one-clock strobe on each debounced press (registered)
//   long    out  one-clock strobe on a long press (registered, or 0)
// ----------------------------------------------------------------------------
module wbc_toggle_bank #(
    parameter int                      CHANNELS    = 4,
    parameter int                      DEBOUNCE_MS = 16,
    parameter logic [2*CHANNELS-1:0]   MODE        = {CHANNELS{2'b01}},
    parameter logic [CHANNELS-1:0]     INIT        = {CHANNELS{1'b0}},
    parameter int                      LONG_MS     = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena_ms,
    input  logic [CHANNELS-1:0] but_n,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] long
);

    // Reject unusable configurations at elaboration time.
    if ((CHANNELS < 1) || (CHANNELS > 16)) begin : g_bad_channels
        $error("wbc_toggle_bank: CHANNELS must be 1..16");
    end
    if (DEBOUNCE_MS < 1) begin : g_bad_debounce
        $error("wbc_toggle_bank: DEBOUNCE_MS must be >= 1");
    end
    if (LONG_MS < 1) begin : g_bad_long
        $error("wbc_toggle_bank: LONG_MS must be >= 1");
    end

    // Debounce counter only ever holds 0..DEBOUNCE_MS-1 between strobes;
    // the terminal value is recognised on the increment and never stored.
    localparam int            CW       = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_MS - 1);

    localparam logic [1:0] MODE_LEVEL  = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_PULSE  = 2'b10;
    localparam logic [1:0] MODE_LEVEL2 = 2'b11;

    // Mode field of one channel.
    function automatic logic [1:0] mode_of(input int ch);
        return MODE[2*ch +: 2];
    endfunction

    // Reset value of the output vector: INIT only applies to toggle channels,
    // level and pulse outputs always come out of reset low.
    function automatic logic [CHANNELS-1:0] calc_out_rst();
        logic [CHANNELS-1:0] v;
        v = {CHANNELS{1'b0}};
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (MODE[2*ch +: 2] == MODE_TOGGLE) begin
                v[ch] = INIT[ch];
            end else begin
                v[ch] = 1'b0;
            end
        end
        return v;
    endfunction

    localparam logic [CHANNELS-1:0] OUT_RST = calc_out_rst();

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;
    logic [CHANNELS-1:0] stable_q;
    logic [CHANNELS-1:0] stable_d;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];
    logic [CHANNELS-1:0] press_q;
    logic [CHANNELS-1:0] out_q;
    logic [CHANNELS-1:0] out_d;

    logic [CHANNELS-1:0] raw_s;   // 1 = button pressed, synchronised
    logic [CHANNELS-1:0] rise_s;  // stable goes 0->1 this clock

    // Two-flop synchroniser; reset to 1 so a held button looks released
    // until it has passed through both stages again.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= {CHANNELS{1'b1}};
            sync2_q <= {CHANNELS{1'b1}};
        end else begin
            sync1_q <= but_n;
            sync2_q <= sync1_q;
        end
    end

    assign raw_s = ~sync2_q;

    // Debounce: count strobes while the input disagrees with the accepted
    // level; any agreeing clock restarts the count, even on a strobe clock.
    always_comb begin
        stable_d = stable_q;
        rise_s   = {CHANNELS{1'b0}};
        for (int ch = 0; ch < CHANNELS; ch++) begin
            cnt_d[ch] = cnt_q[ch];
            if (raw_s[ch] == stable_q[ch]) begin
                cnt_d[ch] = {CW{1'b0}};
            end else if (ena_ms) begin
                if (cnt_q[ch] == DEB_LAST) begin
                    stable_d[ch] = raw_s[ch];
                    cnt_d[ch]    = {CW{1'b0}};
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CW'(1);
                end
            end else begin
                cnt_d[ch] = cnt_q[ch];
            end
            rise_s[ch] = stable_d[ch] & ~stable_q[ch];
        end
    end

    // Per-channel output selection; evaluated against the next accepted
    // level so out and press change on the same clock.
    always_comb begin
        out_d = out_q;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            case (mode_of(ch))
                MODE_LEVEL:  out_d[ch] = stable_d[ch];
                MODE_TOGGLE: out_d[ch] = out_q[ch] ^ rise_s[ch];
                MODE_PULSE:  out_d[ch] = rise_s[ch];
                MODE_LEVEL2: out_d[ch] = stable_d[ch];
                default:     out_d[ch] = stable_d[ch];
            endcase
        end
    end

    // Debounce state, press strobe and mode output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= {CHANNELS{1'b0}};
            press_q  <= {CHANNELS{1'b0}};
            out_q    <= OUT_RST;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt_q[ch] <= {CW{1'b0}};
            end
        end else begin
            stable_q <= stable_d;
            press_q  <= rise_s;
            out_q    <= out_d;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

    assign out   = out_q;
    assign press = press_q;

`ifdef WBC_TOGGLE_LONG_EN
    // ------------------------------------------------------------------
    // Long-press detection
    // ------------------------------------------------------------------
    localparam int            HW       = $clog2(LONG_MS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_MS);

    logic [HW-1:0]       hold_q [CHANNELS];
    logic [HW-1:0]       hold_d [CHANNELS];
    logic [CHANNELS-1:0] long_q;
    logic [CHANNELS-1:0] long_d;

    // Hold counter: cleared while released, counts strobes while the press
    // is accepted and parks at LONG_MS, so only one strobe per press.
    always_comb begin
        long_d = {CHANNELS{1'b0}};
        for (int ch = 0; ch < CHANNELS; ch++) begin
            hold_d[ch] = hold_q[ch];
            if (!stable_q[ch]) begin
                hold_d[ch] = {HW{1'b0}};
            end else if (ena_ms && (hold_q[ch] != HOLD_MAX)) begin
                hold_d[ch] = hold_q[ch] + HW'(1);
                long_d[ch] = (hold_q[ch] == (HOLD_MAX - HW'(1)));
            end else begin
                hold_d[ch] = hold_q[ch];
            end
        end
    end

    // Hold counters and long strobe register.
    always_ff @(posedge clk) begin
        if (rst) begin
            long_q <= {CHANNELS{1'b0}};
            for (int ch = 0; ch < CHANNELS; ch++) begin
                hold_q[ch] <= {HW{1'b0}};
            end
        end else begin
            long_q <= long_d;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                hold_q[ch] <= hold_d[ch];
            end
        end
    end

    assign long = long_q;
`else
    assign long = {CHANNELS{1'b0}};
`endif

endmodule
